// File: rtl/isla_tx_pkg.sv
// Shared definitions for the ISLA transmit pattern generator and the receiver-side checker.
package isla_tx_pkg;

    localparam logic [2:0] MODE_CONST  = 3'd0;
    localparam logic [2:0] MODE_RAMP   = 3'd1;
    localparam logic [2:0] MODE_PRBS   = 3'd2;
    localparam logic [2:0] MODE_TOGGLE = 3'd3;
    localparam logic [2:0] MODE_EXT    = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StStream,
        StFinish
    } tx_state_e;

    // Taps for x^16+x^14+x^13+x^11+1, applied to state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [15:0] TOGGLE_A = 16'hAAAA;
    localparam logic [15:0] TOGGLE_B = 16'h5555;

    typedef struct packed {
        logic [7:0] rise;
        logic [7:0] fall;
    } tx_lanes_t;

    // Lane i carries bit 2i on the rising edge and bit 2i+1 on the falling edge
    function automatic tx_lanes_t word_to_lanes(input logic [15:0] w);
        tx_lanes_t l;
        for (int i = 0; i < 8; i++) begin
            l.rise[i] = w[2*i];
            l.fall[i] = w[2*i+1];
        end
        return l;
    endfunction

endpackage

// File: rtl/isla_tx_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
module isla_tx_lfsr16
    import isla_tx_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (adv_i) begin
            state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/isla_tx_pattern_gen.sv
// ISLA ADC LVDS DDR output emulator: builds 16-bit sample words and splits them into
// rise/fall lane halves for external ODDR primitives. Every output is registered.
module isla_tx_pattern_gen
    import isla_tx_pkg::*;
#(
    parameter logic [15:0] PREAMBLE_WORD = 16'hA5C3,
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [15:0] PRBS_SEED     = 16'hACE1,
    parameter logic [15:0] IDLE_WORD     = 16'h0000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [2:0]  mode,
    input  logic        preamble_en,
    input  logic [15:0] burst_len,
    input  logic [15:0] const_word,
    input  logic [15:0] ext_data,
    input  logic        ext_valid,
    output logic        ext_ready,
    output logic [7:0]  tx_d_rise,
    output logic [7:0]  tx_d_fall,
    output logic        tx_frame,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic [15:0] word_cnt
);

    localparam logic [7:0] PreLast = 8'(PREAMBLE_LEN - 1);
    localparam tx_lanes_t IdleLanes = word_to_lanes(IDLE_WORD);

    tx_state_e   state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [15:0] burst_q, burst_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] ramp_q, ramp_d;
    logic        phase_q, phase_d;
    logic [15:0] last_q, last_d;
    logic        stop_pend_q, stop_pend_d;

    logic [15:0] wcnt_q, wcnt_d;
    logic        underrun_q, underrun_d;
    tx_lanes_t   lanes_q, lanes_d;
    logic        frame_q, frame_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ext_ready_q, ext_ready_d;

    logic        lfsr_load, lfsr_adv;
    logic [15:0] lfsr_state;
    logic [15:0] word;
    logic        last_word;

    isla_tx_lfsr16 #(
        .Seed(PRBS_SEED)
    ) u_lfsr (
        .clk_i  (sys_clk),
        .rst_ni (rst_n),
        .load_i (lfsr_load),
        .seed_i (PRBS_SEED),
        .adv_i  (lfsr_adv),
        .state_o(lfsr_state)
    );

    // Burst end and stop are both evaluated on the word currently being emitted
    assign last_word = stop || stop_pend_q ||
                       ((burst_q != 16'd0) && (wcnt_q == 16'(burst_q - 16'd1)));

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        burst_d     = burst_q;
        pre_cnt_d   = pre_cnt_q;
        ramp_d      = ramp_q;
        phase_d     = phase_q;
        last_d      = last_q;
        stop_pend_d = stop_pend_q;
        wcnt_d      = wcnt_q;
        underrun_d  = underrun_q;
        frame_d     = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        word        = IDLE_WORD;

        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d      = mode;
                    burst_d     = burst_len;
                    pre_cnt_d   = 8'd0;
                    ramp_d      = 16'd0;
                    phase_d     = 1'b0;
                    last_d      = IDLE_WORD;
                    stop_pend_d = 1'b0;
                    wcnt_d      = 16'd0;
                    underrun_d  = 1'b0;
                    lfsr_load   = 1'b1;
                    state_d     = preamble_en ? StPreamble : StStream;
                end
            end
            StPreamble: begin
                word = PREAMBLE_WORD;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (pre_cnt_q == PreLast) begin
                    state_d = StStream;
                end else begin
                    pre_cnt_d = pre_cnt_q + 8'd1;
                end
            end
            StStream: begin
                frame_d = 1'b1;
                wcnt_d  = wcnt_q + 16'd1;
                case (mode_q)
                    MODE_RAMP: begin
                        word   = ramp_q;
                        ramp_d = ramp_q + 16'd1;
                    end
                    MODE_PRBS: begin
                        word     = lfsr_state;
                        lfsr_adv = 1'b1;
                    end
                    MODE_TOGGLE: begin
                        word    = phase_q ? TOGGLE_B : TOGGLE_A;
                        phase_d = ~phase_q;
                    end
                    MODE_EXT: begin
                        if (ext_valid) begin
                            word   = ext_data;
                            last_d = ext_data;
                        end else begin
                            word       = last_q;
                            underrun_d = 1'b1;
                        end
                    end
                    default: word = const_word;
                endcase
                if (last_word) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        lanes_d     = word_to_lanes(word);
        busy_d      = (state_d != StIdle);
        done_d      = (state_q == StFinish);
        ext_ready_d = (state_d == StStream) && (mode_d == MODE_EXT);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= MODE_CONST;
            burst_q     <= 16'd0;
            pre_cnt_q   <= 8'd0;
            ramp_q      <= 16'd0;
            phase_q     <= 1'b0;
            last_q      <= IDLE_WORD;
            stop_pend_q <= 1'b0;
            wcnt_q      <= 16'd0;
            underrun_q  <= 1'b0;
            lanes_q     <= IdleLanes;
            frame_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ext_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            burst_q     <= burst_d;
            pre_cnt_q   <= pre_cnt_d;
            ramp_q      <= ramp_d;
            phase_q     <= phase_d;
            last_q      <= last_d;
            stop_pend_q <= stop_pend_d;
            wcnt_q      <= wcnt_d;
            underrun_q  <= underrun_d;
            lanes_q     <= lanes_d;
            frame_q     <= frame_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ext_ready_q <= ext_ready_d;
        end
    end

    assign tx_d_rise = lanes_q.rise;
    assign tx_d_fall = lanes_q.fall;
    assign tx_frame  = frame_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign word_cnt  = wcnt_q;
    assign ext_ready = ext_ready_q;

endmodule

// File: tb/tb_isla_tx_pattern_gen.sv
// Directed bench for isla_tx_pattern_gen: ramp, PRBS, external underrun, toggle/stop, reset.
module tb_isla_tx_pattern_gen;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        preamble_en = 1'b0;
    logic [15:0] burst_len = 16'd0;
    logic [15:0] const_word = 16'h0000;
    logic [15:0] ext_data = 16'h0000;
    logic        ext_valid = 1'b0;
    logic        ext_ready;
    logic [7:0]  tx_d_rise;
    logic [7:0]  tx_d_fall;
    logic        tx_frame;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [15:0] word_cnt;
    logic [15:0] tx_word;

    int total = 0;
    int bad = 0;

    logic        ev_valid [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] ev_data  [4] = '{16'h1111, 16'h0000, 16'h2222, 16'h3333};
    logic [15:0] ev_word  [4] = '{16'h1111, 16'h1111, 16'h2222, 16'h3333};
    logic        ev_under [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    isla_tx_pattern_gen #(
        .PREAMBLE_WORD(16'hA5C3),
        .PREAMBLE_LEN (4),
        .PRBS_SEED    (16'hACE1),
        .IDLE_WORD    (16'h0000)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .preamble_en(preamble_en),
        .burst_len  (burst_len),
        .const_word (const_word),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .tx_d_rise  (tx_d_rise),
        .tx_d_fall  (tx_d_fall),
        .tx_frame   (tx_frame),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .word_cnt   (word_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] join_lanes(input logic [7:0] r, input logic [7:0] f);
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            w[2*i]   = r[i];
            w[2*i+1] = f[i];
        end
        return w;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always_comb tx_word = join_lanes(tx_d_rise, tx_d_fall);

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk16({tag, "_word"}, tx_word, 16'h0000);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_frame"}, tx_frame, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_underrun"}, underrun, 1'b0);
        chk1({tag, "_ext_ready"}, ext_ready, 1'b0);
        chk16({tag, "_word_cnt"}, word_cnt, 16'h0000);
    endtask

    initial begin
        logic [15:0] s;

        // Power-up reset
        tick();
        tick();
        chk_reset_vals("por");
        rst_n = 1'b1;
        tick();

        // Ramp with preamble, burst 4
        mode = 3'd1;
        preamble_en = 1'b1;
        burst_len = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("ramp_busy_rise", busy, 1'b1);
        chk16("ramp_pre_idle", tx_word, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk16($sformatf("ramp_w%0d", i), tx_word, (i < 4) ? 16'hA5C3 : 16'(i - 4));
            chk1($sformatf("ramp_frame%0d", i), tx_frame, (i >= 4));
            chk1($sformatf("ramp_busy%0d", i), busy, 1'b1);
            chk1($sformatf("ramp_done%0d", i), done, 1'b0);
            if (i == 7) begin
                // 0003 sets bits 0 and 1: lane 0 in both halves
                chk16("ramp_rise_0003", {8'h00, tx_d_rise}, 16'h0001);
                chk16("ramp_fall_0003", {8'h00, tx_d_fall}, 16'h0001);
            end
        end
        tick();
        chk16("ramp_idle", tx_word, 16'h0000);
        chk1("ramp_done", done, 1'b1);
        chk1("ramp_busy_fall", busy, 1'b0);
        chk1("ramp_frame_end", tx_frame, 1'b0);
        chk16("ramp_cnt", word_cnt, 16'd4);
        tick();
        chk1("ramp_done_single", done, 1'b0);

        // PRBS, no preamble, burst 3
        mode = 3'd2;
        preamble_en = 1'b0;
        burst_len = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = 16'hACE1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk16($sformatf("prbs_w%0d", i), tx_word, s);
            chk1($sformatf("prbs_nz%0d", i), (tx_word != 16'h0000), 1'b1);
            chk1($sformatf("prbs_frame%0d", i), tx_frame, 1'b1);
            if (i == 2) begin
                chk16("prbs_w2_hand", tx_word, 16'hB387);
            end
            s = lfsr_next(s);
        end
        tick();
        chk1("prbs_done", done, 1'b1);
        chk16("prbs_idle", tx_word, 16'h0000);
        chk16("prbs_cnt", word_cnt, 16'd3);

        // External stream with one underrun gap
        mode = 3'd4;
        burst_len = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("ext_ready_on", ext_ready, 1'b1);
        chk1("ext_under_clr", underrun, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ext_valid = ev_valid[i];
            ext_data = ev_data[i];
            tick();
            chk16($sformatf("ext_w%0d", i), tx_word, ev_word[i]);
            chk1($sformatf("ext_under%0d", i), underrun, ev_under[i]);
            chk16($sformatf("ext_cnt%0d", i), word_cnt, 16'(i + 1));
        end
        ext_valid = 1'b0;
        chk1("ext_ready_off", ext_ready, 1'b0);
        tick();
        chk1("ext_done", done, 1'b1);
        chk1("ext_under_held", underrun, 1'b1);
        tick();
        chk1("ext_under_held_idle", underrun, 1'b1);

        // Toggle, continuous, stop after 10 words; a start mid-stream must be ignored
        mode = 3'd3;
        burst_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("tog_under_cleared", underrun, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1;
                mode = 3'd1;
            end
            tick();
            start = 1'b0;
            mode = 3'd3;
            chk16($sformatf("tog_w%0d", i), tx_word, (i % 2 == 1) ? 16'h5555 : 16'hAAAA);
            chk16($sformatf("tog_cnt%0d", i), word_cnt, 16'(i + 1));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk16("tog_stop_word", tx_word, 16'hAAAA);
        chk1("tog_stop_frame", tx_frame, 1'b1);
        tick();
        chk1("tog_done", done, 1'b1);
        chk16("tog_idle", tx_word, 16'h0000);
        chk16("tog_cnt", word_cnt, 16'd11);
        chk1("tog_busy_off", busy, 1'b0);

        // Reset mid-stream
        mode = 3'd1;
        burst_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk16("rst_pre_word", tx_word, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        tick();
        chk1("rst_no_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("rst_rel_done", done, 1'b0);
        chk1("rst_rel_busy", busy, 1'b0);

        // Fresh ramp burst after reset starts over from 0 behind the preamble
        preamble_en = 1'b1;
        burst_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk16($sformatf("post_w%0d", i), tx_word, (i < 4) ? 16'hA5C3 : 16'(i - 4));
        end
        tick();
        chk1("post_done", done, 1'b1);
        chk16("post_cnt", word_cnt, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
